// File: rtl/image_pkg.sv
// image_pkg
//   Shared constants and types for the raster-scan ROM reader.
//   Image geometry, ROM timing, output buffer sizing, the scan FSM state
//   type and a small popcount helper for the in-flight valid pipe.
package image_pkg;

  localparam int unsigned IMG_W      = 32;  // pixels per line
  localparam int unsigned IMG_H      = 32;  // lines per frame
  localparam int unsigned ADDR_W     = 10;  // ROM address width
  localparam int unsigned PIX_W      = 8;   // pixel width
  localparam int unsigned ROM_LAT    = 3;   // rom_en high to rom_data valid
  localparam int unsigned FIFO_DEPTH = 4;   // output buffer depth, power of 2, >= ROM_LAT

  localparam int unsigned NUM_PIX = IMG_W * IMG_H;
  localparam int unsigned X_W     = $clog2(IMG_W);
  localparam int unsigned Y_W     = $clog2(IMG_H);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;  // holds 0..FIFO_DEPTH
  localparam int unsigned INF_W   = $clog2(ROM_LAT + 1);     // holds 0..ROM_LAT
  localparam int unsigned OCC_W   = CNT_W + 1;               // in-flight + buffered

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } scan_state_t;

  // Number of reads currently travelling through the ROM latency pipe.
  function automatic logic [INF_W-1:0] count_ones(input logic [ROM_LAT-1:0] v);
    logic [INF_W-1:0] n;
    n = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      n = n + INF_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// pix_fifo
//   Small synchronous FIFO buffering ROM pixels ahead of the valid/ready
//   output. Head entry is presented combinationally on rd_data.
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         synchronous clear of pointers and count (wins over push/pop)
//   push, wr_data write request and data
//   pop           read request (advances head)
//   rd_data       current head entry
//   count         number of stored entries (0..DEPTH)
//   empty         count == 0
module pix_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign rd_en   = pop && !empty;
  // A push into a full FIFO is still safe when the head leaves in the same cycle.
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

endmodule

// File: rtl/image_scan_ctrl.sv
// image_scan_ctrl
//   Raster-scan read sequencer for the IMG_W x IMG_H pixel ROM. A start pulse
//   issues one ROM read per address 0..NUM_PIX-1; returned pixels are buffered
//   and streamed over valid/ready with x/y coordinates and line/frame flags.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a frame (accepted from IDLE only)
//   abort               drop everything in flight and return to IDLE, no done
//   busy                frame in progress (RUN or DRAIN)
//   done                one-cycle pulse after the last pixel is handshaken
//   rom_en, rom_addr    ROM read enable and address (address delayed ROM_LAT-1)
//   rom_data            ROM read data, valid ROM_LAT cycles after rom_en
//   pix_data, pix_valid, pix_ready   output stream
//   pix_x, pix_y        coordinates of pix_data
//   pix_sol, pix_eol, pix_sof, pix_eof   start/end of line/frame flags
module image_scan_ctrl
  import image_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_sof,
  output logic              pix_eof
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(IMG_H - 1);

  scan_state_t       state_q, state_d;
  logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [ROM_LAT-1:0] valid_pipe_q;
  logic [ADDR_W-1:0] addr_pipe_q [ROM_LAT-1];
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;

  logic              issue;
  logic              frame_start;
  logic              flush;
  logic              handshake;
  logic              credit_ok;
  logic              drain_done;
  logic [INF_W-1:0]  inflight;
  logic [OCC_W-1:0]  occupancy;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [PIX_W-1:0]  fifo_rd_data;

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (valid_pipe_q[ROM_LAT-1]),
    .wr_data (rom_data),
    .pop     (handshake),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign pix_valid = !fifo_empty;
  assign handshake = pix_valid && pix_ready;
  assign inflight  = count_ones(valid_pipe_q);

  // Every read in flight has a reserved FIFO slot. A pop this cycle frees one,
  // so the issue test is inflight + count - pop < FIFO_DEPTH, written without
  // subtraction.
  assign occupancy = OCC_W'(inflight) + OCC_W'(fifo_count);
  assign credit_ok = occupancy < (OCC_W'(FIFO_DEPTH) + OCC_W'(handshake));

  // Nothing left to deliver once this cycle completes; lets done follow the
  // final handshake by one cycle.
  assign drain_done = (inflight == '0) &&
                      (fifo_empty || ((fifo_count == CNT_W'(1)) && handshake));

  // Next-state / issue logic
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    issue       = 1'b0;
    frame_start = 1'b0;
    flush       = 1'b0;
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      issue_cnt_d = '0;
      flush       = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d     = RUN;
            issue_cnt_d = '0;
            frame_start = 1'b1;
          end
        end
        RUN: begin
          if (credit_ok) begin
            issue = 1'b1;
            if (issue_cnt_q == LAST_ADDR) begin
              state_d     = DRAIN;
              issue_cnt_d = '0;
            end else begin
              issue_cnt_d = issue_cnt_q + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Coordinate counters follow accepted pixels
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (flush || frame_start) begin
      x_d = '0;
      y_d = '0;
    end else if (handshake) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  // ROM timing: rom_addr must reach the ROM ROM_LAT-1 cycles after rom_en,
  // and the data is captured ROM_LAT cycles after rom_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe_q <= '0;
      for (int i = 0; i < ROM_LAT - 1; i++) begin
        addr_pipe_q[i] <= '0;
      end
    end else begin
      valid_pipe_q <= flush ? '0 : {valid_pipe_q[ROM_LAT-2:0], issue};
      // First stage only loads on issue so rom_addr holds its last value when idle.
      if (issue) begin
        addr_pipe_q[0] <= issue_cnt_q;
      end
      for (int i = 1; i < ROM_LAT - 1; i++) begin
        addr_pipe_q[i] <= addr_pipe_q[i-1];
      end
    end
  end

  assign rom_en   = issue;
  assign rom_addr = addr_pipe_q[ROM_LAT-2];
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  // Data and flags are forced low without a valid pixel so idle/reset outputs read 0.
  assign pix_data = pix_valid ? fifo_rd_data : '0;
  assign pix_x    = x_q;
  assign pix_y    = y_q;
  assign pix_sol  = pix_valid && (x_q == '0);
  assign pix_eol  = pix_valid && (x_q == X_LAST);
  assign pix_sof  = pix_valid && (x_q == '0) && (y_q == '0);
  assign pix_eof  = pix_valid && (x_q == X_LAST) && (y_q == Y_LAST);

endmodule
